cy_control_reg: RTL and testbench
=================================

# cy_control_reg

Firmware-writable 8-bit control register that drives eight nets into UDB/routing logic. It is the write-side counterpart of the status register primitive: the CPU writes a value over a simple single-clock register bus and hardware consumes it as `control_0`…`control_7`. Each bit is either a level bit, which holds until rewritten, or a pulse bit, which self-clears after a programmable number of clocks.

## Interface
Parameters:
- `Bit0Mode`…`Bit7Mode`, default 0: per-bit mode. 0 = level (hold), 1 = pulse (self-clearing). `ModeMask = {Bit7Mode..Bit0Mode}`.
- `InitValue`, default 8'h00: reset value of level bits. Pulse bits always reset to 0.
- `PulseWidth`, default 1: clocks a pulse bit stays high. Legal range 1..255.

Ports:
- `clock`  in  1: sole clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `bus_we`  in  1: write strobe, sampled on the rising edge.
- `bus_re`  in  1: read strobe, sampled on the rising edge.
- `bus_addr`  in  2: 0 = DATA, 1 = SET, 2 = CLR, 3 = MODE (read-only).
- `bus_wdata`  in  8: write data.
- `bus_rdata`  out  8: registered read data; valid while `bus_ack` is high.
- `bus_ack`  out  1: one-cycle acknowledge for each accepted access.
- `update`  out  1: one-cycle strobe that fires whenever the register contents change due to a write.
- `control_0`…`control_7`  out  1 each: registered control nets.

## Operation
- Register `ctl[7:0]` drives `control_n = ctl[n]`.
- Writes sampled at edge k:
  - DATA: `ctl <= wdata`.
  - SET: `ctl <= ctl | wdata`.
  - CLR: `ctl <= ctl & ~wdata`.
  - MODE: ignored, but still acked.
- Reads sampled at edge k:
  - `bus_rdata <= ctl` for DATA.
  - `ModeMask` for MODE.
  - 0 for SET and CLR.
- Simultaneous `bus_we` and `bus_re`: the write is performed and the read is ignored. `bus_rdata` is 0 and a single ack is issued.
- Pulse FSM has two states, IDLE and PULSE. It uses a shared down-counter `cnt`, sized to hold PulseWidth.
  - IDLE → PULSE: a write leaves any pulse bit set (`ctl & ModeMask != 0`). `cnt <= PulseWidth-1`.
  - PULSE: `cnt` decrements each clock. When `cnt == 0` and there is no write, pulse bits clear (`ctl <= ctl & ~ModeMask`), then → IDLE.
  - Write during PULSE: the new pulse bits are merged per the opcode. If any pulse bit remains set, `cnt` reloads to `PulseWidth-1` and all pulse bits are extended. If no pulse bit remains set (e.g. via CLR), → IDLE immediately.
  - A write that sets 0 in pulse bits never starts a pulse.
- `update` asserts the cycle after a write edge only if `ctl` changed value. Pulse self-clear does not assert `update`.
- Reset: `ctl = InitValue & ~ModeMask`, FSM = IDLE, `cnt = 0`, `bus_ack = 0`, `bus_rdata = 0`, `update = 0`.
- Reset mid-pulse: pulse bits drop asynchronously and no residual pulse follows deassertion.

## Timing
- Write latency: `control_n` reflects the write immediately after edge k. `bus_ack` and `update` are high for cycle k→k+1.
- Read latency: one clock. `bus_rdata` and `bus_ack` are valid for cycle k→k+1. `bus_rdata` returns to 0 when no read is pending.
- Pulse bits are high for exactly PulseWidth clock cycles, edge k to edge k+PulseWidth.
- Back-to-back accesses are allowed every clock, with one ack per access. There is no backpressure.

## Structure
- Shared package holds:
  - Address constants: `CTL_ADDR_DATA`, `CTL_ADDR_SET`, `CTL_ADDR_CLR`, `CTL_ADDR_MODE`.
  - Pulse FSM state encoding: `CTL_ST_IDLE`, `CTL_ST_PULSE`.
- One sub-module is natural: `cy_ctl_pulse_timer`, containing the FSM and counter. Its inputs are `start` and `clear_all`; its output is `expire`.
- The bus decode and `ctl` register live in the top module.

## Test plan
- Reset with InitValue=8'hA5, Bit0Mode=1: `control` = 8'hA4. `bus_ack`, `bus_rdata` and `update` are all 0.
- Level behaviour, all level bits: write DATA 8'h3C, then SET 8'h81, then CLR 8'h0C. `control` steps 3C → BD → B1. Each access gives one ack, and `update` asserts 3 times.
- Pulse behaviour, Bit2Mode=1, PulseWidth=4: write DATA 8'h04. `control_2` is high for exactly 4 clocks, then 0, with no `update` at expiry. A read of DATA after expiry returns 8'h00.
- Pulse extension, PulseWidth=4: write SET 8'h04, then SET 8'h04 two clocks later. `control_2` is high for 6 clocks total. A CLR 8'h04 issued mid-pulse drops the bit on the next edge and the FSM goes to IDLE.
- Read and collision: simultaneous we+re to DATA with 8'h55 gives `control` = 55, `bus_rdata` = 0, and one ack. A read of MODE returns ModeMask. A write of 8'hFF to MODE is acked and leaves `control` unchanged.
- Asynchronous reset mid-pulse, PulseWidth=10: assert `reset` 3 clocks into a pulse. The pulse bits drop without waiting for a clock edge, and `control` stays at the reset value after release.

Source files
------------

// File: rtl/cy_control_reg_pkg.sv
// Shared definitions for the cy_control_reg block.
// Holds the bus address map, the pulse FSM state encoding and the pulse
// counter width. The counter width covers the largest PulseWidth, which is 255.
package cy_control_reg_pkg;

    localparam logic [1:0] CTL_ADDR_DATA = 2'd0;
    localparam logic [1:0] CTL_ADDR_SET  = 2'd1;
    localparam logic [1:0] CTL_ADDR_CLR  = 2'd2;
    localparam logic [1:0] CTL_ADDR_MODE = 2'd3;

    localparam int CTL_CNT_W = 8;

    typedef enum logic {
        CTL_ST_IDLE  = 1'b0,
        CTL_ST_PULSE = 1'b1
    } ctl_state_e;

endpackage

// File: rtl/cy_ctl_pulse_timer.sv
// Pulse-bit timer for cy_control_reg.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : a write leaves at least one pulse bit set; (re)load the counter
//   clear_all : a write leaves every pulse bit clear; abandon the pulse
//   expire    : combinational; pulse bits clear on this edge
//
// state        | meaning
// CTL_ST_IDLE  | no pulse bit is high
// CTL_ST_PULSE | pulse bits high, cnt_q counts the clocks remaining
module cy_ctl_pulse_timer #(
    parameter int PulseWidth = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic clear_all,
    output logic expire
);
    import cy_control_reg_pkg::*;

    // Loading PulseWidth-1 keeps the bit high from edge k through edge k+PulseWidth.
    localparam logic [CTL_CNT_W-1:0] Reload = CTL_CNT_W'(PulseWidth - 1);

    ctl_state_e           state_q, state_d;
    logic [CTL_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CTL_ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        case (state_q)
            CTL_ST_IDLE: begin
                if (start) begin
                    state_d = CTL_ST_PULSE;
                    cnt_d   = Reload;
                end
            end
            CTL_ST_PULSE: begin
                if (start) begin
                    cnt_d = Reload;
                end else if (clear_all) begin
                    state_d = CTL_ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    expire  = 1'b1;
                    state_d = CTL_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CTL_CNT_W'(1);
                end
            end
            default: begin
                state_d = CTL_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/cy_control_reg.sv
// Firmware-writable 8-bit control register driving eight routing nets.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   bus_we, bus_re      : write / read strobes, one access per asserted cycle
//   bus_addr            : 0 DATA, 1 SET, 2 CLR, 3 MODE (read-only)
//   bus_wdata           : write data
//   bus_rdata, bus_ack  : registered read data and one-cycle acknowledge
//   update              : one-cycle strobe when a write changed the register
//   control_0..7        : register bits; level bits hold, pulse bits self-clear
module cy_control_reg #(
    parameter bit         Bit0Mode   = 1'b0,
    parameter bit         Bit1Mode   = 1'b0,
    parameter bit         Bit2Mode   = 1'b0,
    parameter bit         Bit3Mode   = 1'b0,
    parameter bit         Bit4Mode   = 1'b0,
    parameter bit         Bit5Mode   = 1'b0,
    parameter bit         Bit6Mode   = 1'b0,
    parameter bit         Bit7Mode   = 1'b0,
    parameter logic [7:0] InitValue  = 8'h00,
    parameter int         PulseWidth = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bus_we,
    input  logic       bus_re,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_ack,
    output logic       update,
    output logic       control_0,
    output logic       control_1,
    output logic       control_2,
    output logic       control_3,
    output logic       control_4,
    output logic       control_5,
    output logic       control_6,
    output logic       control_7
);
    import cy_control_reg_pkg::*;

    localparam logic [7:0] ModeMask = {Bit7Mode, Bit6Mode, Bit5Mode, Bit4Mode,
                                       Bit3Mode, Bit2Mode, Bit1Mode, Bit0Mode};
    localparam logic [7:0] ResetValue = InitValue & ~ModeMask;

    logic [7:0] ctl_q, ctl_d, ctl_wr;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, update_q;
    logic       pulse_start, pulse_clear, expire;

    always_comb begin
        ctl_wr = ctl_q;
        case (bus_addr)
            CTL_ADDR_DATA: ctl_wr = bus_wdata;
            CTL_ADDR_SET:  ctl_wr = ctl_q | bus_wdata;
            CTL_ADDR_CLR:  ctl_wr = ctl_q & ~bus_wdata;
            default:       ctl_wr = ctl_q;
        endcase
    end

    // Any write re-evaluates the pulse bits: still set extends, none set ends the pulse.
    assign pulse_start = bus_we && ((ctl_wr & ModeMask) != 8'h00);
    assign pulse_clear = bus_we && !pulse_start;

    cy_ctl_pulse_timer #(
        .PulseWidth(PulseWidth)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .start    (pulse_start),
        .clear_all(pulse_clear),
        .expire   (expire)
    );

    always_comb begin
        ctl_d = ctl_q;
        if (bus_we) begin
            ctl_d = ctl_wr;
        end else if (expire) begin
            ctl_d = ctl_q & ~ModeMask;
        end
    end

    // A write wins over a simultaneous read, so the read returns zero.
    always_comb begin
        rdata_d = 8'h00;
        if (bus_re && !bus_we) begin
            case (bus_addr)
                CTL_ADDR_DATA: rdata_d = ctl_q;
                CTL_ADDR_MODE: rdata_d = ModeMask;
                default:       rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl_q    <= ResetValue;
            rdata_q  <= 8'h00;
            ack_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            ctl_q    <= ctl_d;
            rdata_q  <= rdata_d;
            ack_q    <= bus_we || bus_re;
            update_q <= bus_we && (ctl_wr != ctl_q);
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ack   = ack_q;
    assign update    = update_q;
    assign control_0 = ctl_q[0];
    assign control_1 = ctl_q[1];
    assign control_2 = ctl_q[2];
    assign control_3 = ctl_q[3];
    assign control_4 = ctl_q[4];
    assign control_5 = ctl_q[5];
    assign control_6 = ctl_q[6];
    assign control_7 = ctl_q[7];

endmodule

// File: tb/tb_cy_control_reg.sv
module tb_cy_control_reg;
    import cy_control_reg_pkg::*;

    logic       clock = 1'b0;
    logic       rst_a, rst_b;
    logic       we, re;
    logic [1:0] addr;
    logic [7:0] wdata;
    int         sel;

    logic       a_we, a_re, b_we, b_re;
    logic [7:0] a_rdata, b_rdata, a_c, b_c;
    logic       a_ack, b_ack, a_upd, b_upd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign a_we = we && (sel == 0);
    assign a_re = re && (sel == 0);
    assign b_we = we && (sel == 1);
    assign b_re = re && (sel == 1);

    // A: pulse bits 0 and 2, PulseWidth 4, reset value A5 & ~05 = A0
    cy_control_reg #(
        .Bit0Mode(1'b1), .Bit2Mode(1'b1), .InitValue(8'hA5), .PulseWidth(4)
    ) dut_a (
        .clock(clock), .reset(rst_a), .bus_we(a_we), .bus_re(a_re),
        .bus_addr(addr), .bus_wdata(wdata), .bus_rdata(a_rdata),
        .bus_ack(a_ack), .update(a_upd),
        .control_0(a_c[0]), .control_1(a_c[1]), .control_2(a_c[2]), .control_3(a_c[3]),
        .control_4(a_c[4]), .control_5(a_c[5]), .control_6(a_c[6]), .control_7(a_c[7])
    );

    // B: pulse bit 6 only, PulseWidth 10, reset value 42 & ~40 = 02
    cy_control_reg #(
        .Bit6Mode(1'b1), .InitValue(8'h42), .PulseWidth(10)
    ) dut_b (
        .clock(clock), .reset(rst_b), .bus_we(b_we), .bus_re(b_re),
        .bus_addr(addr), .bus_wdata(wdata), .bus_rdata(b_rdata),
        .bus_ack(b_ack), .update(b_upd),
        .control_0(b_c[0]), .control_1(b_c[1]), .control_2(b_c[2]), .control_3(b_c[3]),
        .control_4(b_c[4]), .control_5(b_c[5]), .control_6(b_c[6]), .control_7(b_c[7])
    );

    typedef struct {
        int         s;
        bit         w;
        bit         r;
        logic [1:0] ad;
        logic [7:0] wd;
        logic [7:0] ctl;
        bit         ack;
        logic [7:0] rd;
        bit         upd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int s, input bit w, input bit r, input logic [1:0] ad,
                                input logic [7:0] wd, input logic [7:0] ctl, input bit ack,
                                input logic [7:0] rd, input bit upd);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.ad = ad; v.wd = wd;
        v.ctl = ctl; v.ack = ack; v.rd = rd; v.upd = upd;
        return v;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, let the rising edge sample, then look 1 ns later.
    task automatic cyc(input int s, input bit w, input bit r, input logic [1:0] ad,
                       input logic [7:0] wd);
        @(negedge clock);
        sel = s; we = w; re = r; addr = ad; wdata = wd;
        @(posedge clock);
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        we = 1'b0; re = 1'b0; addr = 2'd0; wdata = 8'h00; sel = 0;

        // A: DATA 04 -> bit 2 high for 4 samples, no update at expiry, read back 00
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_DATA, 8'h04, 8'h04, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, CTL_ADDR_DATA, 8'h00, 8'h00, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        // A: SET 04, SET 04 two clocks later -> 6 samples high; second SET changes nothing
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_SET, 8'h04, 8'h04, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_SET, 8'h04, 8'h04, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        // A: CLR mid-pulse drops at once; a later pulse on bit 0 gets the full 4 clocks
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_SET, 8'h04, 8'h04, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h04, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_CLR, 8'h04, 8'h00, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_SET, 8'h01, 8'h01, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h01, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h01, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h01, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        // A: we+re collision to DATA 55 -> write wins, rdata 0; bits 0/2 then expire
        vecs.push_back(mk(0, 1, 1, CTL_ADDR_DATA, 8'h55, 8'h55, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h55, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h55, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h55, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h50, 0, 8'h00, 0));
        // A: MODE read, MODE write ignored, SET reads 0, level writes and DATA read
        vecs.push_back(mk(0, 0, 1, CTL_ADDR_MODE, 8'h00, 8'h50, 1, 8'h05, 0));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_MODE, 8'hFF, 8'h50, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, CTL_ADDR_SET, 8'h00, 8'h50, 1, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_CLR, 8'hF0, 8'h00, 1, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, CTL_ADDR_DATA, 8'hAA, 8'hAA, 1, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, CTL_ADDR_DATA, 8'h00, 8'hAA, 1, 8'hAA, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'hAA, 0, 8'h00, 0));
        // B: level bits 3C -> BD -> B1, then DATA and MODE reads
        vecs.push_back(mk(1, 1, 0, CTL_ADDR_DATA, 8'h3C, 8'h3C, 1, 8'h00, 1));
        vecs.push_back(mk(1, 1, 0, CTL_ADDR_SET, 8'h81, 8'hBD, 1, 8'h00, 1));
        vecs.push_back(mk(1, 1, 0, CTL_ADDR_CLR, 8'h0C, 8'hB1, 1, 8'h00, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'hB1, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 1, CTL_ADDR_DATA, 8'h00, 8'hB1, 1, 8'hB1, 0));
        vecs.push_back(mk(1, 0, 1, CTL_ADDR_MODE, 8'h00, 8'hB1, 1, 8'h40, 0));
        vecs.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'hB1, 0, 8'h00, 0));

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check8("rst A ctl", a_c, 8'hA0);
        check8("rst A ack", {7'd0, a_ack}, 8'h00);
        check8("rst A rdata", a_rdata, 8'h00);
        check8("rst A update", {7'd0, a_upd}, 8'h00);
        check8("rst B ctl", b_c, 8'h02);
        @(negedge clock);
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clock);
        #1;
        check8("post-rst A ctl", a_c, 8'hA0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [7:0] c, rd;
            logic       ak, up;
            cyc(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].ad, vecs[i].wd);
            c  = (vecs[i].s == 0) ? a_c : b_c;
            rd = (vecs[i].s == 0) ? a_rdata : b_rdata;
            ak = (vecs[i].s == 0) ? a_ack : b_ack;
            up = (vecs[i].s == 0) ? a_upd : b_upd;
            check8($sformatf("vec%0d ctl", i), c, vecs[i].ctl);
            check8($sformatf("vec%0d rdata", i), rd, vecs[i].rd);
            check8($sformatf("vec%0d ack", i), {7'd0, ak}, {7'd0, vecs[i].ack});
            check8($sformatf("vec%0d update", i), {7'd0, up}, {7'd0, vecs[i].upd});
        end

        // B: asynchronous reset 3 clocks into a 10-clock pulse
        cyc(1, 1, 0, CTL_ADDR_SET, 8'h40);
        check8("B pulse start", b_c, 8'hF1);
        cyc(1, 0, 0, 2'd0, 8'h00);
        cyc(1, 0, 0, 2'd0, 8'h00);
        check8("B pulse mid", b_c, 8'hF1);
        #2;
        rst_b = 1'b1;
        #1;
        check8("B async rst ctl", b_c, 8'h02);
        repeat (2) @(negedge clock);
        rst_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 2'd0, 8'h00);
            check8($sformatf("B after rst ctl %0d", i), b_c, 8'h02);
            check8($sformatf("B after rst update %0d", i), {7'd0, b_upd}, 8'h00);
        end

        // B: a fresh pulse after reset lasts exactly 10 clocks
        cyc(1, 1, 0, CTL_ADDR_SET, 8'h40);
        check8("B pw10 start", b_c, 8'h42);
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 0, 2'd0, 8'h00);
            check8($sformatf("B pw10 cycle %0d", i), b_c, (i < 10) ? 8'h42 : 8'h02);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
